// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg
//   Shared definitions for the truth-table sweeper: FSM state encoding,
//   vector geometry and the step -> applied-vector mapping.
//   Build option: define GRAY_ORDER_EN to walk the vectors in Gray-code
//   order (one input toggles per step); default is binary order 0..15.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;
  localparam int NUM_OUTPUTS = 3;

  // Vector applied at a given sweep step. Either order visits every
  // vector exactly once, so the captured tables are order-independent.
  function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] step);
`ifdef GRAY_ORDER_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_counter.sv
// sweep_dwell_counter
//   Counts clocks spent on the current vector. Wraps to zero on the
//   cycle it reaches DWELL_CYCLES-1 while enabled.
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous clear to zero (wins over en)
//   en     in   count enable
//   last   out  high while count == DWELL_CYCLES-1
module sweep_dwell_counter #(
  parameter int DWELL_CYCLES = 100,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives all 16 {A,B,C,D} vectors into a 4-in/3-out combinational
//   circuit, holds each for DWELL_CYCLES clocks and captures the three
//   outputs on the last dwell cycle into 16-bit truth tables.
//   Build option: GRAY_ORDER_EN selects Gray-code vector order.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle sweep request (ignored while busy)
//   abort                       synchronous cancel, beats start
//   F_alpha, F_beta, F_gamma    circuit outputs under test
//   A, B, C, D                  registered stimulus, A = vector MSB
//   busy                        sweep in progress
//   done                        sweep complete, until next start/abort
//   table_alpha/beta/gamma      bit i = output sampled with {A,B,C,D}==i
//
// state    | meaning
// ST_IDLE  | stimulus at 0, waiting for start
// ST_DRIVE | holding a vector, sampling on the last dwell cycle
// ST_DONE  | all 16 vectors captured, last vector held
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int DWELL_CYCLES = 100,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        F_alpha,
  input  logic        F_beta,
  input  logic        F_gamma,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_alpha,
  output logic [15:0] table_beta,
  output logic [15:0] table_gamma
);

  localparam logic [VEC_W-1:0] LAST_STEP = VEC_W'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   step_q, step_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [15:0]        tbl_a_q, tbl_a_d;
  logic [15:0]        tbl_b_q, tbl_b_d;
  logic [15:0]        tbl_g_q, tbl_g_d;
  logic               cnt_clear, cnt_en, dwell_last;

  sweep_dwell_counter #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .last  (dwell_last)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    vec_d     = vec_q;
    tbl_a_d   = tbl_a_q;
    tbl_b_d   = tbl_b_q;
    tbl_g_d   = tbl_g_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    if (abort) begin
      // Tables keep whatever was captured before the cancel.
      state_d   = ST_IDLE;
      step_d    = '0;
      vec_d     = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_DRIVE;
            step_d    = '0;
            vec_d     = vec_of('0);
            tbl_a_d   = '0;
            tbl_b_d   = '0;
            tbl_g_d   = '0;
            cnt_clear = 1'b1;
          end
        end
        ST_DRIVE: begin
          cnt_en = 1'b1;
          if (dwell_last) begin
            // Index by the applied vector, not the step, so Gray order
            // lands each sample in the same bit as binary order.
            tbl_a_d[vec_q] = F_alpha;
            tbl_b_d[vec_q] = F_beta;
            tbl_g_d[vec_q] = F_gamma;
            if (step_q == LAST_STEP) begin
              state_d = ST_DONE;
            end else begin
              step_d = step_q + VEC_W'(1);
              vec_d  = vec_of(step_q + VEC_W'(1));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      vec_q   <= '0;
      tbl_a_q <= '0;
      tbl_b_q <= '0;
      tbl_g_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      vec_q   <= vec_d;
      tbl_a_q <= tbl_a_d;
      tbl_b_q <= tbl_b_d;
      tbl_g_q <= tbl_g_d;
    end
  end

  assign {A, B, C, D}  = vec_q;
  assign busy          = (state_q == ST_DRIVE);
  assign done          = (state_q == ST_DONE);
  assign table_alpha   = tbl_a_q;
  assign table_beta    = tbl_b_q;
  assign table_gamma   = tbl_g_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
//   Drives the sweeper against a behavioural circuit whose three outputs
//   are looked up in bench-held 16-bit function tables, and checks the
//   applied vector sequence, busy/done timing and captured tables.
module tb_truth_table_sweeper;

  localparam int DW = 4;

  logic        clk, rst_n, start, abort;
  logic        F_alpha, F_beta, F_gamma;
  logic        A, B, C, D, busy, done;
  logic [15:0] table_alpha, table_beta, table_gamma;

  logic [15:0] fn_a, fn_b, fn_g;
  logic [3:0]  applied;

  int n_tests = 0;
  int n_fail  = 0;

  truth_table_sweeper #(
    .DWELL_CYCLES (DW),
    .CNT_W        (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .F_alpha     (F_alpha),
    .F_beta      (F_beta),
    .F_gamma     (F_gamma),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .busy        (busy),
    .done        (done),
    .table_alpha (table_alpha),
    .table_beta  (table_beta),
    .table_gamma (table_gamma)
  );

  assign applied = {A, B, C, D};
  assign F_alpha = fn_a[applied];
  assign F_beta  = fn_b[applied];
  assign F_gamma = fn_g[applied];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_vec(input int s);
`ifdef GRAY_ORDER_EN
    return 4'(s ^ (s >> 1));
`else
    return 4'(s);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sweep from IDLE or DONE. Optional events, by edge number after the
  // accepting edge (-1 = none): a stray start, an abort, an async reset.
  task automatic sweep(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                       input int mid_start, input int abort_at, input int rst_at);
    logic [15:0] mask;
    mask = '0;
    fn_a = a; fn_b = b; fn_g = g;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("tbl_clear", {table_alpha, table_beta, table_gamma}, 48'h0);
    check("vec_first", {busy, done, applied}, {2'b10, ref_vec(0)});
    for (int k = 1; k <= 16*DW; k++) begin
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1 check("rst_mid", {busy, done, applied, table_alpha, table_beta, table_gamma}, 64'h0);
        #1 rst_n = 1'b1;
        return;
      end
      if (k == mid_start) start = 1'b1;
      if (k == abort_at)  abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (k == abort_at) begin
        check("abort_out", {busy, done, applied}, 6'h0);
        check("abort_tbl", {table_alpha, table_beta, table_gamma},
              {a & mask, b & mask, g & mask});
        return;
      end
      if (k % DW == 0) mask[ref_vec(k/DW - 1)] = 1'b1;
      if (k < 16*DW) begin
        check("seq", {busy, done, applied}, {2'b10, ref_vec(k/DW)});
      end else begin
        check("done", {busy, done, applied}, {2'b01, ref_vec(15)});
        check("tables", {table_alpha, table_beta, table_gamma}, {a, b, g});
      end
    end
    @(posedge clk); #1;
    check("done_hold", {busy, done, table_alpha, table_beta, table_gamma},
          {2'b01, a, b, g});
  endtask

  initial begin
    logic [15:0] ra, rb, rg;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    fn_a = '0; fn_b = '0; fn_g = '0;
    #1 rst_n = 1'b0;
    #1 check("reset", {busy, done, applied, table_alpha, table_beta, table_gamma}, 64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle", {busy, done, applied}, 6'h0);

    // A&B, ~D, 0
    sweep(16'hF000, 16'h5555, 16'h0000, -1, -1, -1);
    // stray start during vector 5, restarted from DONE
    sweep(16'hF000, 16'h5555, 16'h0000, 5*DW + 1, -1, -1);

    ra = 16'($urandom); rb = 16'($urandom); rg = 16'($urandom);
    sweep(ra, rb, rg, -1, 9*DW + 2, -1);
    @(posedge clk); #1;
    check("idle_after_abort", {busy, done, applied}, 6'h0);
    sweep(ra, rb, rg, -1, -1, -1);

    // abort beats start while in DONE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_wins", {busy, done, applied}, 6'h0);
    check("abort_keep", {table_alpha, table_beta, table_gamma}, {ra, rb, rg});

    ra = 16'($urandom); rb = 16'($urandom); rg = 16'($urandom);
    sweep(ra, rb, rg, -1, -1, 7*DW + 1);
    @(posedge clk); #1;
    check("post_rst_idle", {busy, done, applied}, 6'h0);

    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rg = 16'($urandom);
      sweep(ra, rb, rg, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
